// File: rtl/ysyx_23060111_lsu_if.sv
// Signal bundle between the LSU, the EXU that feeds it, the word-wide memory
// bus and the writeback stage. The LSU takes the slave view; the surrounding
// environment (EXU, memory, writeback) takes the master view.
interface ysyx_23060111_lsu_if;
    // EXU -> LSU operation handshake
    logic        in_valid;
    logic        in_ready;
    logic        in_is_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd;

    // LSU <-> memory bus
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    // LSU -> writeback
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_err;
    logic [1:0]  wb_err_cause;

    modport slave (
        input  in_valid, in_is_store, in_funct3, in_addr, in_wdata, in_rd,
        input  mem_req_ready, mem_rsp_valid, mem_rdata,
        input  wb_ready,
        output in_ready,
        output mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
        output wb_valid, wb_we, wb_rd, wb_data, wb_err, wb_err_cause
    );

    modport master (
        output in_valid, in_is_store, in_funct3, in_addr, in_wdata, in_rd,
        output mem_req_ready, mem_rsp_valid, mem_rdata,
        output wb_ready,
        input  in_ready,
        input  mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
        input  wb_valid, wb_we, wb_rd, wb_data, wb_err, wb_err_cause
    );
endinterface

// File: rtl/ysyx_23060111_lsu.sv
// ysyx_23060111 load/store unit: one memory operation at a time, word-wide
// valid/ready bus, aligned and extended load results, error reporting for
// misaligned accesses, illegal funct3 codes and bus timeouts.
module ysyx_23060111_lsu #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input logic                   clk,
    input logic                   rst,
    ysyx_23060111_lsu_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_MISALGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    state_t           r_state;
    state_t           w_next;

    // Operation captured at acceptance; payload is not reset because every
    // output that exposes it is gated by the (reset) state.
    logic             r_is_store;
    logic [2:0]       r_funct3;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [4:0]       r_rd;
    logic [31:0]      r_rdata;

    logic [1:0]       r_cause;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_timeout;
    logic             w_legal;
    logic             w_misalign;
    logic [1:0]       w_chk_cause;
    logic             w_load_ok;

    // Store byte-lane enables for SB/SH/SW at the given byte offset.
    function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = 4'b0011 << off;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Store data replicated so the active lanes carry the right bytes.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    // Shift the addressed bytes down to bit 0, then sign or zero extend.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] word);
        logic        [31:0] sh;
        logic signed [7:0]  sb;
        logic signed [15:0] shw;
        logic signed [31:0] res;
        sh  = word >> {off, 3'b000};
        sb  = sh[7:0];
        shw = sh[15:0];
        case (f3)
            3'b000:  res = 32'(sb);
            3'b001:  res = 32'(shw);
            3'b100:  res = {24'd0, sh[7:0]};
            3'b101:  res = {16'd0, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    assign w_accept  = (r_state == S_IDLE) && bus.in_valid;
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == TO_LIMIT) &&
                       ((r_state == S_REQ) || (r_state == S_RESP));
    assign w_load_ok = !r_is_store && (r_cause == CAUSE_NONE);

    // Decode legality and alignment of the operation presented by the EXU.
    always_comb begin
        w_legal    = 1'b0;
        w_misalign = 1'b0;
        if (bus.in_is_store) begin
            w_legal = (bus.in_funct3 == 3'b000) || (bus.in_funct3 == 3'b001) ||
                      (bus.in_funct3 == 3'b010);
        end else begin
            w_legal = (bus.in_funct3 == 3'b000) || (bus.in_funct3 == 3'b001) ||
                      (bus.in_funct3 == 3'b010) || (bus.in_funct3 == 3'b100) ||
                      (bus.in_funct3 == 3'b101);
        end
        if (bus.in_funct3[1:0] == 2'b01) begin
            w_misalign = bus.in_addr[0];
        end else if (bus.in_funct3[1:0] == 2'b10) begin
            w_misalign = (bus.in_addr[1:0] != 2'b00);
        end
        if (!w_legal) begin
            w_chk_cause = CAUSE_ILLEGAL;
        end else if (w_misalign) begin
            w_chk_cause = CAUSE_MISALGN;
        end else begin
            w_chk_cause = CAUSE_NONE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; the watchdog wins over a same-cycle handshake or response.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_next = (w_chk_cause != CAUSE_NONE) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (w_timeout) begin
                    w_next = S_DONE;
                end else if (bus.mem_req_ready) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (w_timeout || bus.mem_rsp_valid) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.wb_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Error cause and watchdog counter (control, reset).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cause <= CAUSE_NONE;
            r_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_cause <= w_chk_cause;
                r_cnt   <= '0;
            end else if (w_timeout) begin
                r_cause <= CAUSE_TIMEOUT;
            end else if ((r_state == S_REQ) || (r_state == S_RESP)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Operation payload capture and load result capture (data, not reset).
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_is_store <= bus.in_is_store;
            r_funct3   <= bus.in_funct3;
            r_addr     <= bus.in_addr;
            r_wdata    <= bus.in_wdata;
            r_rd       <= bus.in_rd;
        end
        if ((r_state == S_RESP) && bus.mem_rsp_valid && !w_timeout) begin
            r_rdata <= load_extract(r_funct3, r_addr[1:0], bus.mem_rdata);
        end
    end

    // Outputs decoded from state and the captured operation.
    always_comb begin
        bus.in_ready      = (r_state == S_IDLE);
        bus.mem_req_valid = 1'b0;
        bus.mem_addr      = 32'd0;
        bus.mem_wen       = 1'b0;
        bus.mem_wmask     = 4'd0;
        bus.mem_wdata     = 32'd0;
        bus.wb_valid      = 1'b0;
        bus.wb_we         = 1'b0;
        bus.wb_rd         = 5'd0;
        bus.wb_data       = 32'd0;
        bus.wb_err        = 1'b0;
        bus.wb_err_cause  = 2'b00;
        if ((r_state == S_REQ) && !w_timeout) begin
            bus.mem_req_valid = 1'b1;
            bus.mem_addr      = {r_addr[31:2], 2'b00};
            bus.mem_wen       = r_is_store;
            if (r_is_store) begin
                bus.mem_wmask = store_mask(r_funct3, r_addr[1:0]);
                bus.mem_wdata = store_data(r_funct3, r_wdata);
            end
        end
        if (r_state == S_DONE) begin
            bus.wb_valid     = 1'b1;
            bus.wb_we        = w_load_ok;
            bus.wb_rd        = r_is_store ? 5'd0 : r_rd;
            bus.wb_data      = w_load_ok ? r_rdata : 32'd0;
            bus.wb_err       = (r_cause != CAUSE_NONE);
            bus.wb_err_cause = r_cause;
        end
    end

endmodule

// File: tb/tb_ysyx_23060111_lsu.sv
// Directed testbench for ysyx_23060111_lsu with a 4-cycle watchdog.
module tb_ysyx_23060111_lsu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    ysyx_23060111_lsu_if bus ();

    ysyx_23060111_lsu #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else n_pass++;
        n_total++; if (bus.mem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", bus.mem_req_valid); else n_pass++;
        n_total++; if (bus.wb_valid !== 1'b0) $display("FAIL reset_wb_valid: got %b want 0", bus.wb_valid); else n_pass++;
        n_total++; if (bus.wb_data !== 32'd0) $display("FAIL reset_wb_data: got %h want 0", bus.wb_data); else n_pass++;
        n_total++; if (bus.mem_wmask !== 4'd0) $display("FAIL reset_wmask: got %b want 0", bus.mem_wmask); else n_pass++;
        n_total++; if (bus.wb_err !== 1'b0) $display("FAIL reset_wb_err: got %b want 0", bus.wb_err); else n_pass++;
    endtask

    task automatic test_load();
        logic [2:0]  f3 [5] = '{3'd2, 3'd0, 3'd4, 3'd5, 3'd1};
        logic [31:0] ad [5] = '{32'h8000_0010, 32'h8000_0013, 32'h8000_0013, 32'h8000_0012, 32'h8000_0012};
        logic [31:0] rw [5] = '{32'hDEAD_BEEF, 32'h80FF_FFFF, 32'h80FF_FFFF, 32'h8001_0000, 32'h8001_0000};
        logic [31:0] ex [5] = '{32'hDEAD_BEEF, 32'hFFFF_FF80, 32'h0000_0080, 32'h0000_8001, 32'hFFFF_8001};
        logic [31:0] ea [5] = '{32'h8000_0010, 32'h8000_0010, 32'h8000_0010, 32'h8000_0010, 32'h8000_0010};
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.in_is_store = 1'b0; bus.in_funct3 = f3[i];
            bus.in_addr = ad[i]; bus.in_wdata = 32'h5555_5555; bus.in_rd = 5'(i + 1);
            n_total++; if (bus.in_ready !== 1'b1) $display("FAIL load%0d_in_ready: got %b want 1", i, bus.in_ready); else n_pass++;
            tick();
            bus.in_valid = 1'b0;
            n_total++; if (bus.mem_req_valid !== 1'b1) $display("FAIL load%0d_req_valid: got %b want 1", i, bus.mem_req_valid); else n_pass++;
            n_total++; if (bus.mem_addr !== ea[i]) $display("FAIL load%0d_addr: got %h want %h", i, bus.mem_addr, ea[i]); else n_pass++;
            n_total++; if (bus.mem_wen !== 1'b0) $display("FAIL load%0d_wen: got %b want 0", i, bus.mem_wen); else n_pass++;
            n_total++; if (bus.mem_wmask !== 4'd0) $display("FAIL load%0d_wmask: got %b want 0", i, bus.mem_wmask); else n_pass++;
            n_total++; if (bus.in_ready !== 1'b0) $display("FAIL load%0d_busy: got %b want 0", i, bus.in_ready); else n_pass++;
            tick();
            n_total++; if (bus.mem_req_valid !== 1'b0) $display("FAIL load%0d_req_drop: got %b want 0", i, bus.mem_req_valid); else n_pass++;
            n_total++; if (bus.wb_valid !== 1'b0) $display("FAIL load%0d_wb_early: got %b want 0", i, bus.wb_valid); else n_pass++;
            bus.mem_rsp_valid = 1'b1; bus.mem_rdata = rw[i];
            tick();
            bus.mem_rsp_valid = 1'b0; bus.mem_rdata = 32'd0;
            n_total++; if (bus.wb_valid !== 1'b1) $display("FAIL load%0d_wb_valid: got %b want 1", i, bus.wb_valid); else n_pass++;
            n_total++; if (bus.wb_we !== 1'b1) $display("FAIL load%0d_wb_we: got %b want 1", i, bus.wb_we); else n_pass++;
            n_total++; if (bus.wb_data !== ex[i]) $display("FAIL load%0d_wb_data: got %h want %h", i, bus.wb_data, ex[i]); else n_pass++;
            n_total++; if (bus.wb_rd !== 5'(i + 1)) $display("FAIL load%0d_wb_rd: got %0d want %0d", i, bus.wb_rd, i + 1); else n_pass++;
            n_total++; if (bus.wb_err !== 1'b0) $display("FAIL load%0d_wb_err: got %b want 0", i, bus.wb_err); else n_pass++;
            tick();
            n_total++; if (bus.wb_valid !== 1'b0) $display("FAIL load%0d_wb_drop: got %b want 0", i, bus.wb_valid); else n_pass++;
            n_total++; if (bus.in_ready !== 1'b1) $display("FAIL load%0d_ready_again: got %b want 1", i, bus.in_ready); else n_pass++;
        end
    endtask

    task automatic test_store();
        logic [2:0]  f3 [3] = '{3'd0, 3'd1, 3'd2};
        logic [31:0] ad [3] = '{32'h8000_0001, 32'h8000_0002, 32'h8000_0004};
        logic [31:0] wd [3] = '{32'h1234_56AB, 32'h0000_BEEF, 32'hCAFE_F00D};
        logic [3:0]  em [3] = '{4'b0010, 4'b1100, 4'b1111};
        logic [31:0] ed [3] = '{32'hABAB_ABAB, 32'hBEEF_BEEF, 32'hCAFE_F00D};
        logic [31:0] ea [3] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0004};
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.in_is_store = 1'b1; bus.in_funct3 = f3[i];
            bus.in_addr = ad[i]; bus.in_wdata = wd[i]; bus.in_rd = 5'd7;
            tick();
            bus.in_valid = 1'b0;
            n_total++; if (bus.mem_req_valid !== 1'b1) $display("FAIL store%0d_req_valid: got %b want 1", i, bus.mem_req_valid); else n_pass++;
            n_total++; if (bus.mem_wen !== 1'b1) $display("FAIL store%0d_wen: got %b want 1", i, bus.mem_wen); else n_pass++;
            n_total++; if (bus.mem_addr !== ea[i]) $display("FAIL store%0d_addr: got %h want %h", i, bus.mem_addr, ea[i]); else n_pass++;
            n_total++; if (bus.mem_wmask !== em[i]) $display("FAIL store%0d_wmask: got %b want %b", i, bus.mem_wmask, em[i]); else n_pass++;
            n_total++; if (bus.mem_wdata !== ed[i]) $display("FAIL store%0d_wdata: got %h want %h", i, bus.mem_wdata, ed[i]); else n_pass++;
            tick();
            bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
            tick();
            bus.mem_rsp_valid = 1'b0; bus.mem_rdata = 32'd0;
            n_total++; if (bus.wb_valid !== 1'b1) $display("FAIL store%0d_wb_valid: got %b want 1", i, bus.wb_valid); else n_pass++;
            n_total++; if (bus.wb_we !== 1'b0) $display("FAIL store%0d_wb_we: got %b want 0", i, bus.wb_we); else n_pass++;
            n_total++; if (bus.wb_rd !== 5'd0) $display("FAIL store%0d_wb_rd: got %0d want 0", i, bus.wb_rd); else n_pass++;
            n_total++; if (bus.wb_data !== 32'd0) $display("FAIL store%0d_wb_data: got %h want 0", i, bus.wb_data); else n_pass++;
            n_total++; if (bus.wb_err !== 1'b0) $display("FAIL store%0d_wb_err: got %b want 0", i, bus.wb_err); else n_pass++;
            tick();
        end
    endtask

    task automatic test_errors();
        logic        st [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3 [4] = '{3'd2, 3'd1, 3'd3, 3'd4};
        logic [31:0] ad [4] = '{32'h8000_0002, 32'h8000_0003, 32'h8000_0000, 32'h8000_0000};
        logic [1:0]  ec [4] = '{2'b01, 2'b01, 2'b10, 2'b10};
        logic [4:0]  er [4] = '{5'd9, 5'd0, 5'd9, 5'd0};
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_is_store = st[i]; bus.in_funct3 = f3[i];
            bus.in_addr = ad[i]; bus.in_wdata = 32'h1111_2222; bus.in_rd = 5'd9;
            tick();
            bus.in_valid = 1'b0;
            n_total++; if (bus.mem_req_valid !== 1'b0) $display("FAIL err%0d_no_req: got %b want 0", i, bus.mem_req_valid); else n_pass++;
            n_total++; if (bus.wb_valid !== 1'b1) $display("FAIL err%0d_wb_valid: got %b want 1", i, bus.wb_valid); else n_pass++;
            n_total++; if (bus.wb_err !== 1'b1) $display("FAIL err%0d_wb_err: got %b want 1", i, bus.wb_err); else n_pass++;
            n_total++; if (bus.wb_err_cause !== ec[i]) $display("FAIL err%0d_cause: got %b want %b", i, bus.wb_err_cause, ec[i]); else n_pass++;
            n_total++; if (bus.wb_we !== 1'b0) $display("FAIL err%0d_wb_we: got %b want 0", i, bus.wb_we); else n_pass++;
            n_total++; if (bus.wb_data !== 32'd0) $display("FAIL err%0d_wb_data: got %h want 0", i, bus.wb_data); else n_pass++;
            n_total++; if (bus.wb_rd !== er[i]) $display("FAIL err%0d_wb_rd: got %0d want %0d", i, bus.wb_rd, er[i]); else n_pass++;
            tick();
            n_total++; if (bus.in_ready !== 1'b1) $display("FAIL err%0d_ready_again: got %b want 1", i, bus.in_ready); else n_pass++;
        end
    endtask

    task automatic test_timeout();
        bus.mem_req_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_is_store = 1'b0; bus.in_funct3 = 3'd2;
        bus.in_addr = 32'h8000_0020; bus.in_rd = 5'd3;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_total++; if (bus.mem_req_valid !== 1'b1) $display("FAIL tmo_req_hold%0d: got %b want 1", i, bus.mem_req_valid); else n_pass++;
            tick();
        end
        n_total++; if (bus.mem_req_valid !== 1'b0) $display("FAIL tmo_req_drop: got %b want 0", bus.mem_req_valid); else n_pass++;
        n_total++; if (bus.wb_valid !== 1'b0) $display("FAIL tmo_wb_early: got %b want 0", bus.wb_valid); else n_pass++;
        tick();
        n_total++; if (bus.wb_valid !== 1'b1) $display("FAIL tmo_wb_valid: got %b want 1", bus.wb_valid); else n_pass++;
        n_total++; if (bus.wb_err !== 1'b1) $display("FAIL tmo_wb_err: got %b want 1", bus.wb_err); else n_pass++;
        n_total++; if (bus.wb_err_cause !== 2'b11) $display("FAIL tmo_cause: got %b want 11", bus.wb_err_cause); else n_pass++;
        n_total++; if (bus.wb_we !== 1'b0) $display("FAIL tmo_wb_we: got %b want 0", bus.wb_we); else n_pass++;
        tick();
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'h1234_5678;
        tick();
        bus.mem_rsp_valid = 1'b0; bus.mem_rdata = 32'd0;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL late_rsp_ready: got %b want 1", bus.in_ready); else n_pass++;
        n_total++; if (bus.wb_valid !== 1'b0) $display("FAIL late_rsp_wb: got %b want 0", bus.wb_valid); else n_pass++;
        n_total++; if (bus.mem_req_valid !== 1'b0) $display("FAIL late_rsp_req: got %b want 0", bus.mem_req_valid); else n_pass++;
    endtask

    task automatic test_backpressure();
        bus.wb_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_is_store = 1'b0; bus.in_funct3 = 3'd1;
        bus.in_addr = 32'h8000_0032; bus.in_rd = 5'd12;
        tick();
        bus.in_valid = 1'b0;
        tick();
        bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'h7F00_0000;
        tick();
        bus.mem_rsp_valid = 1'b0; bus.mem_rdata = 32'd0;
        bus.in_valid = 1'b1; bus.in_addr = 32'h8000_0040; bus.in_funct3 = 3'd2;
        for (int i = 0; i < 3; i++) begin
            n_total++; if (bus.wb_valid !== 1'b1) $display("FAIL bp%0d_wb_valid: got %b want 1", i, bus.wb_valid); else n_pass++;
            n_total++; if (bus.wb_data !== 32'h0000_7F00) $display("FAIL bp%0d_wb_data: got %h want 00007f00", i, bus.wb_data); else n_pass++;
            n_total++; if (bus.wb_rd !== 5'd12) $display("FAIL bp%0d_wb_rd: got %0d want 12", i, bus.wb_rd); else n_pass++;
            n_total++; if (bus.in_ready !== 1'b0) $display("FAIL bp%0d_in_ready: got %b want 0", i, bus.in_ready); else n_pass++;
            tick();
        end
        bus.in_valid = 1'b0;
        bus.wb_ready = 1'b1;
        tick();
        n_total++; if (bus.wb_valid !== 1'b0) $display("FAIL bp_release: got %b want 0", bus.wb_valid); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL bp_idle: got %b want 1", bus.in_ready); else n_pass++;
    endtask

    task automatic test_reset_in_resp();
        bus.in_valid = 1'b1; bus.in_is_store = 1'b0; bus.in_funct3 = 3'd2;
        bus.in_addr = 32'h8000_0050; bus.in_rd = 5'd5;
        tick();
        bus.in_valid = 1'b0;
        tick();
        n_total++; if (bus.mem_req_valid !== 1'b0) $display("FAIL rr_in_resp: got %b want 0", bus.mem_req_valid); else n_pass++;
        rst = 1'b1;
        bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'hAAAA_5555;
        tick();
        rst = 1'b0;
        bus.mem_rsp_valid = 1'b0; bus.mem_rdata = 32'd0;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL rr_in_ready: got %b want 1", bus.in_ready); else n_pass++;
        n_total++; if (bus.wb_valid !== 1'b0) $display("FAIL rr_wb_valid: got %b want 0", bus.wb_valid); else n_pass++;
        n_total++; if (bus.wb_data !== 32'd0) $display("FAIL rr_wb_data: got %h want 0", bus.wb_data); else n_pass++;
        tick();
        n_total++; if (bus.wb_valid !== 1'b0) $display("FAIL rr_discard: got %b want 0", bus.wb_valid); else n_pass++;
        n_total++; if (bus.mem_req_valid !== 1'b0) $display("FAIL rr_no_req: got %b want 0", bus.mem_req_valid); else n_pass++;
    endtask

    initial begin
        bus.in_valid      = 1'b0;
        bus.in_is_store   = 1'b0;
        bus.in_funct3     = 3'd0;
        bus.in_addr       = 32'd0;
        bus.in_wdata      = 32'd0;
        bus.in_rd         = 5'd0;
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = 32'd0;
        bus.wb_ready      = 1'b1;
        test_reset();
        test_load();
        test_store();
        test_errors();
        test_timeout();
        test_backpressure();
        test_reset_in_resp();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ysyx_23060111_lsu.md
Name: ysyx_23060111_lsu

Overview:
Load/store unit directly downstream of the EXU in the ysyx_23060111 RV32 core. It accepts one memory operation at a time from the EXU: effective address, store data and funct3. It drives a word-wide memory bus with valid/ready requests and responses, then returns aligned and sign/zero-extended load data with a register-write request to writeback. It detects misaligned accesses, illegal funct3 codes and bus timeouts, and reports each as an error instead of accessing memory.

Parameters:
TIMEOUT, 255, max cycles waiting in REQ+RESP before error; 0 disables watchdog
CNT_W, 8, watchdog counter width; must hold TIMEOUT

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  EXU presents an operation
in_ready  out  1  LSU can accept (high only in IDLE)
in_is_store  in  1  1=store, 0=load
in_funct3  in  3  RV32 width/sign code
in_addr  in  32  effective byte address
in_wdata  in  32  store data (rs2)
in_rd  in  5  load destination register
mem_req_valid  out  1  bus request valid
mem_req_ready  in  1  bus accepts request
mem_addr  out  32  word address {addr[31:2],2'b00}
mem_wen  out  1  1=write
mem_wmask  out  4  byte enables (writes only; 0 for reads)
mem_wdata  out  32  store data shifted to byte lane
mem_rsp_valid  in  1  bus response/write ack
mem_rdata  in  32  read word
wb_valid  out  1  result ready for writeback
wb_ready  in  1  writeback consumes result
wb_we  out  1  register write requested (loads without error)
wb_rd  out  5  destination register
wb_data  out  32  extended load data; 0 for stores/errors
wb_err  out  1  misaligned/illegal/timeout
wb_err_cause  out  2  01 misaligned, 10 illegal funct3, 11 timeout

Behaviour:
- States IDLE, REQ, RESP, DONE. Reset: state IDLE, in_ready=1; all other outputs 0; watchdog cleared.
- IDLE: in_ready=1. On in_valid: register op, addr, wdata, rd and offset=addr[1:0].
  - Legal funct3: stores 000/001/010; loads 000/001/010/100/101. Anything else goes to DONE with cause 10.
  - Misaligned: half with addr[0]=1, word with addr[1:0]!=0. Goes to DONE with cause 01. No bus activity.
  - Otherwise go to REQ.
- REQ: mem_req_valid=1; mem_addr, mem_wen, mem_wmask, mem_wdata held stable until mem_req_ready. Handshake moves to RESP.
- Store lanes: SB mask=0001<<off, data={4{wdata[7:0]}}. SH mask=0011<<off, data={2{wdata[15:0]}}. SW mask=1111, data=wdata.
- RESP: mem_req_valid=0. On mem_rsp_valid: capture, go to DONE.
- Load extract: word>>(8*off). LB/LH sign-extend; LBU/LHU zero-extend; LW whole word.
- mem_rsp_valid outside RESP is ignored.
- Watchdog: counts every cycle in REQ or RESP and resets on entry to REQ. If TIMEOUT!=0 and count reaches TIMEOUT, go to DONE with cause 11, dropping mem_req_valid that same cycle.
- DONE: wb_valid=1; wb_* held stable until wb_ready. wb_we=1 only for error-free loads.
  - wb_rd = in_rd for loads, 0 for stores.
  - On wb_ready: return to IDLE; wb_valid drops next cycle.
- Minimum latency, zero-wait bus and wb_ready tied high: accept at cycle N, req handshake N+1, rsp N+2, wb_valid N+3, in_ready again N+4. Error path: wb_valid at N+1.
- rst in any state aborts the operation immediately: next cycle is IDLE with all outputs at reset values; pending responses are discarded.
- Only one operation in flight; in_valid is ignored outside IDLE.

Test Plan:
- LW addr=0x8000_0010, mem_rdata=0xDEADBEEF, zero-wait -> mem_addr=0x8000_0010, mem_wen=0; wb_valid at N+3, wb_we=1, wb_data=0xDEADBEEF.
- LB addr=0x8000_0013, rdata=0x80FF_FFFF -> wb_data=0xFFFF_FF80. LBU same -> 0x0000_0080. LHU addr=..12, rdata=0x8001_0000 -> 0x0000_8001.
- SB addr=0x8000_0001, wdata=0x1234_56AB -> mem_wmask=0010, mem_wdata=0xABABABAB, mem_wen=1; wb_we=0, wb_err=0.
- LW addr=0x8000_0002 and SH addr=0x8000_0003 -> no mem_req_valid ever, wb_err=1, cause=01, wb_valid at N+1. funct3=011 -> cause 10.
- mem_req_ready held 0, TIMEOUT=4 -> mem_req_valid drops after 4 cycles, wb_err=1, cause=11. Then a late mem_rsp_valid pulse in IDLE -> no effect.
- wb_ready low for 3 cycles with wb_valid high -> wb_* stable, in_ready=0. rst asserted in RESP -> next cycle IDLE, outputs zero, in_ready=1.
